eth_rx_framer: RTL and testbench
================================

ETH_RX_FRAMER -- requirements
Module: eth_rx_framer

Interface
REQ-001 SHALL have parameter MTU, default 1536, meaning rx buffer size in bytes and maximum accepted frame length.
REQ-002 SHALL have parameter MIN_LEN, default 14, meaning minimum accepted payload length in bytes (header only, FCS excluded).
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 rx_dv  input  1  byte strobe from PHY side; high = rx_data valid this cycle; falling edge ends frame.
REQ-006 rx_data  input  8  received octet, preamble/SFD included.
REQ-007 rx_er  input  1  PHY error flag, sampled with rx_dv.
REQ-008 wr_en  output  1  rx buffer byte write strobe.
REQ-009 wr_addr  output  16  rx buffer byte address, 0-based per frame.
REQ-010 wr_data  output  8  rx buffer byte.
REQ-011 frm_valid  output  1  completed frame held in buffer, awaiting host.
REQ-012 frm_len  output  16  byte length of held frame, valid while frm_valid.
REQ-013 frm_rel  input  1  one-cycle host pulse releasing the buffer.
REQ-014 busy  output  1  high while a frame is being written (states SFD-accepted through DONE).
REQ-015 n_drop  output  16  saturating count of discarded frames.

Function
REQ-016 States SHALL be IDLE, PRE, DATA, DROP, DONE.
REQ-017 IDLE: rx_dv with rx_data 0x55 SHALL go to PRE; any other byte with rx_dv SHALL go to DROP.
REQ-018 PRE: 0x55 SHALL stay; 0xD5 SHALL go to DATA if buffer free (frm_valid low, or frm_rel this cycle), else DROP; other byte or rx_er SHALL go to DROP; rx_dv low SHALL return to IDLE without counting.
REQ-019 DATA: each rx_dv byte SHALL assert wr_en same-edge registered output one cycle later, wr_addr = byte index, index incremented after write.
REQ-020 DATA: rx_er high SHALL go to DROP; byte index reaching MTU+4 SHALL go to DROP (oversize).
REQ-021 DATA: rx_dv low SHALL go to DONE.
REQ-022 DONE (one cycle): if length checks pass, frm_valid SHALL rise next cycle with frm_len; else n_drop increments and frm_valid stays low; then IDLE.
REQ-023 DROP: SHALL suppress wr_en, wait for rx_dv low, increment n_drop once, return to IDLE.
REQ-024 frm_valid SHALL stay high until frm_rel; frm_rel while frm_valid low SHALL be ignored.
REQ-025 frm_rel coincident with SFD SHALL free the buffer and accept the new frame.
REQ-026 n_drop SHALL saturate at 0xFFFF, never wrap.
REQ-027 Buffer writes SHALL never occur while frm_valid is high.
REQ-028 Latency: last data byte to frm_valid SHALL be 3 clk cycles.

Reset
REQ-029 On rst_n low, asynchronously: state IDLE, wr_en 0, wr_addr 0, wr_data 0, frm_valid 0, frm_len 0, busy 0, n_drop 0, CRC register all-ones.
REQ-030 Reset mid-frame SHALL abandon the frame without counting; after release, bytes before next 0x55 preamble SHALL be dropped per REQ-017.

Configuration
REQ-031 Macro ETH_RX_CRC_CHECK_EN defined: CRC-32 (poly 0x04C11DB7 reflected, init 0xFFFFFFFF) over all DATA bytes; residue != 0xDEBB20E3 at DONE SHALL drop and count; frm_len = bytes - 4 (FCS stripped); length check MIN_LEN <= frm_len <= MTU.
REQ-032 Macro undefined: no CRC logic; frm_len = bytes written; length check MIN_LEN <= frm_len <= MTU; oversize limit in REQ-020 becomes MTU.

Structure
REQ-033 Shared package eth_pkg SHALL hold state enum, PREAMBLE 0x55, SFD 0xD5, CRC polynomial and residue constants.
REQ-034 One sub-module eth_crc32 (byte-wide combinational next-CRC) SHALL be instantiated only under ETH_RX_CRC_CHECK_EN.

Verification
REQ-035 7x0x55, 0xD5, 60 bytes + valid FCS -> 64 wr_en pulses addr 0..63, frm_valid with frm_len 60 (CRC on) / 64 (CRC off), n_drop 0.
REQ-036 Same frame with one payload bit flipped, CRC on -> frm_valid stays low, n_drop 1.
REQ-037 Second frame while frm_valid high and no frm_rel -> zero wr_en, n_drop +1, first frame_len unchanged.
REQ-038 frm_rel pulsed on SFD cycle of second frame -> second frame accepted, frm_len updated.
REQ-039 rx_er at byte 20, then 1600-byte frame -> n_drop 2, no frm_valid.
REQ-040 rst_n low at byte 30 of frame -> all outputs zero, n_drop 0; next good frame accepted normally.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive framer.
// Receiver states, preamble/SFD octets, CRC-32 constants and small helpers.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_DROP,
    ST_DONE
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE    = 8'h55;
  localparam logic [7:0]  SFD         = 8'hD5;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Register value left after running the CRC over payload plus a correct FCS.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide combinational CRC-32 step (reflected, LSB-first bit order).
// Only instantiated by the framer when ETH_RX_CRC_CHECK_EN is defined.
module eth_crc32
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  logic [31:0] c_work;

  always_comb begin
    c_work = crc_i ^ {24'd0, data_i};
    for (int k = 0; k < 8; k++) begin
      c_work = c_work[0] ? ((c_work >> 1) ^ POLY_REFL) : (c_work >> 1);
    end
    crc_o = c_work;
  end

endmodule

// File: rtl/eth_rx_framer.sv
// Ethernet receive framer: strips preamble/SFD, writes frame bytes into a single rx buffer
// and hands completed frames to the host. Define ETH_RX_CRC_CHECK_EN to verify and strip the FCS.
module eth_rx_framer
  import eth_pkg::*;
#(
  parameter int MTU     = 1536,
  parameter int MIN_LEN = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  input  logic        rx_er,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        frm_valid,
  output logic [15:0] frm_len,
  input  logic        frm_rel,
  output logic        busy,
  output logic [15:0] n_drop
);

`ifdef ETH_RX_CRC_CHECK_EN
  localparam logic [15:0] FCS_LEN = 16'd4;
`else
  localparam logic [15:0] FCS_LEN = 16'd0;
`endif
  localparam logic [15:0] MTU_W   = 16'(MTU);
  localparam logic [15:0] MIN_W   = 16'(MIN_LEN);
  // Largest number of bytes a frame may put on the wire, FCS included when it is checked.
  localparam logic [15:0] LIMIT   = MTU_W + FCS_LEN;
  localparam logic [15:0] MIN_RAW = MIN_W + FCS_LEN;

  rx_state_e   state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        frm_valid_q, frm_valid_d;
  logic [15:0] frm_len_q, frm_len_d;
  logic [15:0] n_drop_q, n_drop_d;
  logic        crc_ok;
  logic        crc_restart;
  logic        crc_step;
  logic        len_ok;
  logic        buf_free;

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_next;

  eth_crc32 u_crc (
    .crc_i  (crc_q),
    .data_i (rx_data),
    .crc_o  (crc_next)
  );

  always_comb begin
    crc_d = crc_q;
    if (crc_restart) begin
      crc_d = CRC_INIT;
    end else if (crc_step) begin
      crc_d = crc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_ok = (crc_q == CRC_RESIDUE);
`else
  assign crc_ok = 1'b1;
`endif

  assign len_ok   = (idx_q >= MIN_RAW) && (idx_q <= LIMIT);
  // A release arriving together with the SFD frees the buffer for this very frame.
  assign buf_free = !frm_valid_q || frm_rel;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frm_valid_d = frm_valid_q;
    frm_len_d   = frm_len_q;
    n_drop_d    = n_drop_q;
    crc_restart = 1'b0;
    crc_step    = 1'b0;

    if (frm_rel) begin
      frm_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (rx_dv) begin
          state_d = (rx_data == PREAMBLE) ? ST_PRE : ST_DROP;
        end
      end

      ST_PRE: begin
        if (!rx_dv) begin
          state_d = ST_IDLE;
        end else if (rx_er) begin
          state_d = ST_DROP;
        end else if (rx_data == PREAMBLE) begin
          state_d = ST_PRE;
        end else if ((rx_data == SFD) && buf_free) begin
          state_d     = ST_DATA;
          idx_d       = '0;
          crc_restart = 1'b1;
        end else begin
          state_d = ST_DROP;
        end
      end

      ST_DATA: begin
        if (!rx_dv) begin
          state_d = ST_DONE;
        end else if (rx_er || (idx_q == LIMIT)) begin
          state_d = ST_DROP;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = rx_data;
          idx_d     = idx_q + 16'd1;
          crc_step  = 1'b1;
        end
      end

      ST_DONE: begin
        if (len_ok && crc_ok) begin
          frm_valid_d = 1'b1;
          frm_len_d   = idx_q - FCS_LEN;
        end else begin
          n_drop_d = sat_inc16(n_drop_q);
        end
        state_d = ST_IDLE;
      end

      ST_DROP: begin
        if (!rx_dv) begin
          n_drop_d = sat_inc16(n_drop_q);
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frm_valid_q <= 1'b0;
      frm_len_q   <= '0;
      n_drop_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frm_valid_q <= frm_valid_d;
      frm_len_q   <= frm_len_d;
      n_drop_q    <= n_drop_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frm_valid = frm_valid_q;
  assign frm_len   = frm_len_q;
  assign n_drop    = n_drop_q;
  assign busy      = (state_q == ST_DATA) || (state_q == ST_DONE);

endmodule

// File: tb/tb_eth_rx_framer.sv
// Directed bench for eth_rx_framer: good/bad frames, buffer hand-off, length limits, reset.
// Builds under both settings of ETH_RX_CRC_CHECK_EN.
module tb_eth_rx_framer;

`ifdef ETH_RX_CRC_CHECK_EN
  localparam int FCS_ADJ = 4;
`else
  localparam int FCS_ADJ = 0;
`endif
  localparam int MTU     = 1536;
  localparam int MIN_LEN = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_er = 1'b0;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        frm_valid;
  logic [15:0] frm_len;
  logic        frm_rel = 1'b0;
  logic        busy;
  logic [15:0] n_drop;

  eth_rx_framer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_dv     (rx_dv),
    .rx_data   (rx_data),
    .rx_er     (rx_er),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frm_valid (frm_valid),
    .frm_len   (frm_len),
    .frm_rel   (frm_rel),
    .busy      (busy),
    .n_drop    (n_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  int          wr_cnt    = 0;
  int          addr_err  = 0;
  int          wr_bad    = 0;
  logic [15:0] last_addr = 16'd0;

  logic [7:0] fb [0:2047];

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      if (wr_addr != 16'd0 && wr_addr != last_addr + 16'd1) addr_err++;
      last_addr = wr_addr;
      if (frm_valid) wr_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    logic        fb_bit;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb_bit = c[0] ^ fb[i][b];
        c = c >> 1;
        if (fb_bit) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic build_frame(input int npay, input int flip_bit, output int total);
    logic [31:0] fcs;
    for (int i = 0; i < npay; i++) fb[i] = 8'((i * 7 + 3) & 255);
    fcs = fcs_of(npay);
    for (int k = 0; k < 4; k++) fb[npay + k] = fcs[8*k +: 8];
    if (flip_bit >= 0) fb[flip_bit / 8][flip_bit % 8] = ~fb[flip_bit / 8][flip_bit % 8];
    total = npay + 4;
  endtask

  task automatic drv(input logic dv, input logic [7:0] d, input logic er);
    @(negedge clk);
    rx_dv = dv; rx_data = d; rx_er = er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 8'h00, 1'b0);
  endtask

  // Ends one negedge after the edge that samples the last byte, with rx_dv already low.
  task automatic send_frame(input int n, input bit rel_sfd, input int er_at);
    for (int i = 0; i < 7; i++) drv(1'b1, 8'h55, 1'b0);
    @(negedge clk);
    rx_dv = 1'b1; rx_data = 8'hD5; rx_er = 1'b0; frm_rel = rel_sfd;
    for (int i = 0; i < n; i++) begin
      drv(1'b1, fb[i], (i == er_at));
      frm_rel = 1'b0;
    end
    drv(1'b0, 8'h00, 1'b0);
    frm_rel = 1'b0;
  endtask

  task automatic release_buf();
    @(negedge clk); frm_rel = 1'b1;
    @(negedge clk); frm_rel = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},     32'(wr_en),     32'd0);
    check({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    check({tag, "_wr_data"},   32'(wr_data),   32'd0);
    check({tag, "_frm_valid"}, 32'(frm_valid), 32'd0);
    check({tag, "_frm_len"},   32'(frm_len),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_n_drop"},    32'(n_drop),    32'd0);
  endtask

  initial begin
    int tot;
    int w0;
    int exp_drop;
    int pay_min;
    int pay_max;
    exp_drop = 0;
    pay_min  = MIN_LEN + FCS_ADJ - 4;
    pay_max  = MTU + FCS_ADJ - 4;

    // Reset values
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    @(negedge clk); rst_n = 1'b1;
    idle(3);

    // Good 60-byte payload + FCS, latency and busy window
    build_frame(60, -1, tot);
    w0 = wr_cnt;
    send_frame(tot, 1'b0, -1);
    @(negedge clk);
    check("good_lat_p1_valid", 32'(frm_valid), 32'd0);
    check("good_lat_p1_busy",  32'(busy),      32'd1);
    @(negedge clk);
    check("good_lat_p2_valid", 32'(frm_valid), 32'd1);
    check("good_lat_p2_busy",  32'(busy),      32'd0);
    check("good_len",       32'(frm_len),   32'(64 - FCS_ADJ));
    check("good_wr_cnt",    32'(wr_cnt - w0), 32'd64);
    check("good_last_addr", 32'(last_addr), 32'd63);
    check("good_addr_seq",  32'(addr_err),  32'd0);
    check("good_n_drop",    32'(n_drop),    32'd0);
    idle(3);

    // Second frame while buffer held and not released
    build_frame(40, -1, tot);
    w0 = wr_cnt;
    send_frame(tot, 1'b0, -1);
    idle(3);
    exp_drop++;
    check("held_wr_cnt", 32'(wr_cnt - w0), 32'd0);
    check("held_n_drop", 32'(n_drop),      32'(exp_drop));
    check("held_len",    32'(frm_len),     32'(64 - FCS_ADJ));
    check("held_valid",  32'(frm_valid),   32'd1);

    // Release on the SFD cycle accepts the new frame
    build_frame(50, -1, tot);
    w0 = wr_cnt;
    send_frame(tot, 1'b1, -1);
    @(negedge clk);
    check("relsfd_p1_valid", 32'(frm_valid), 32'd0);
    @(negedge clk);
    check("relsfd_valid",  32'(frm_valid),   32'd1);
    check("relsfd_len",    32'(frm_len),     32'(54 - FCS_ADJ));
    check("relsfd_wr_cnt", 32'(wr_cnt - w0), 32'd54);
    check("relsfd_n_drop", 32'(n_drop),      32'(exp_drop));
    check("wr_while_held", 32'(wr_bad),      32'd0);

    // Release, then a stray release with nothing held
    release_buf();
    @(negedge clk);
    check("rel_valid", 32'(frm_valid), 32'd0);
    release_buf();
    @(negedge clk);
    check("stray_rel_valid", 32'(frm_valid), 32'd0);
    check("stray_rel_len",   32'(frm_len),   32'(54 - FCS_ADJ));

    // One payload bit flipped
    build_frame(60, 80, tot);
    send_frame(tot, 1'b0, -1);
    idle(3);
`ifdef ETH_RX_CRC_CHECK_EN
    exp_drop++;
    check("badcrc_valid",  32'(frm_valid), 32'd0);
`else
    check("badcrc_valid",  32'(frm_valid), 32'd1);
    check("badcrc_len",    32'(frm_len),   32'd64);
`endif
    check("badcrc_n_drop", 32'(n_drop), 32'(exp_drop));
    release_buf();
    idle(2);

    // Length just below and exactly at the minimum
    build_frame(pay_min - 1, -1, tot);
    send_frame(tot, 1'b0, -1);
    idle(3);
    exp_drop++;
    check("short_valid",  32'(frm_valid), 32'd0);
    check("short_n_drop", 32'(n_drop),    32'(exp_drop));
    build_frame(pay_min, -1, tot);
    send_frame(tot, 1'b0, -1);
    idle(3);
    check("minlen_valid", 32'(frm_valid), 32'd1);
    check("minlen_len",   32'(frm_len),   32'(MIN_LEN));
    release_buf();
    idle(2);

    // Length exactly at and one above MTU
    build_frame(pay_max, -1, tot);
    send_frame(tot, 1'b0, -1);
    idle(3);
    check("mtu_valid", 32'(frm_valid), 32'd1);
    check("mtu_len",   32'(frm_len),   32'(MTU));
    release_buf();
    idle(2);
    build_frame(pay_max + 1, -1, tot);
    send_frame(tot, 1'b0, -1);
    idle(3);
    exp_drop++;
    check("mtu1_valid",  32'(frm_valid), 32'd0);
    check("mtu1_n_drop", 32'(n_drop),    32'(exp_drop));

    // rx_er at byte 20, then a 1600-byte frame
    build_frame(60, -1, tot);
    send_frame(tot, 1'b0, 20);
    idle(3);
    build_frame(1600, -1, tot);
    send_frame(tot, 1'b0, -1);
    idle(3);
    exp_drop += 2;
    check("er_over_n_drop", 32'(n_drop),    32'(exp_drop));
    check("er_over_valid",  32'(frm_valid), 32'd0);
    check("wr_while_held2", 32'(wr_bad),    32'd0);

    // Reset at byte 30 of a frame
    build_frame(60, -1, tot);
    for (int i = 0; i < 7; i++) drv(1'b1, 8'h55, 1'b0);
    drv(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) drv(1'b1, fb[i], 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    for (int i = 30; i < tot; i++) drv(1'b1, fb[i], 1'b0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    w0 = wr_cnt;
    send_frame(tot, 1'b0, -1);
    idle(3);
    check("postrst_valid",  32'(frm_valid),   32'd1);
    check("postrst_len",    32'(frm_len),     32'(64 - FCS_ADJ));
    check("postrst_wr_cnt", 32'(wr_cnt - w0), 32'd64);
    check("postrst_n_drop", 32'(n_drop),      32'd0);
    check("postrst_addr",   32'(addr_err),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
